uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 16x oversampling.
//   Turns frames on the host line into bytes for the command parser.
//   A two-flop synchroniser feeds a majority voter: three samples taken
//   around mid-bit (oversample counts 7, 8, 9) decide each bit.
//   A start bit that does not hold low at mid-bit is treated as a glitch.
//
// Ports
//   clock          in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   ser_in         in   asynchronous serial line, idle high
//   rx_data        out  last correctly received byte (holds until the next one)
//   new_rx_data    out  one-clock strobe, rx_data valid in the same cycle
//   framing_error  out  one-clock strobe, stop bit sampled low
//   rx_busy        out  receiver is not idle
module uart_rx #(
  parameter int unsigned BAUD_DIV = 27  // clocks per oversample tick, 1..65535
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ser_in,
  output logic [7:0] rx_data,
  output logic       new_rx_data,
  output logic       framing_error,
  output logic       rx_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  localparam logic [15:0] DIV_MAX = 16'(BAUD_DIV - 1);

  // Synchroniser; both flops reset to the idle line level.
  logic sync1_q, sync2_q;
  logic sin;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= ser_in;
      sync2_q <= sync1_q;
    end
  end

  assign sin = sync2_q;

  // Free-running oversample tick generator.
  logic [15:0] div_q;
  logic        tick;

  assign tick = (div_q == DIV_MAX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) div_q <= '0;
    else          div_q <= tick ? '0 : div_q + 16'd1;
  end

  // Receiver state.
  logic [2:0] state_q, state_d;
  logic [3:0] os_q, os_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       s7_q, s7_d, s8_q, s8_d;
  logic [7:0] rx_q, rx_d;
  logic       new_q, new_d;
  logic       fe_q, fe_d;
  logic       vote;

  // Samples from counts 7 and 8 are held; the count-9 sample is the live
  // sin, so the vote is only meaningful on the os_q==9 tick.
  assign vote = (s7_q & s8_q) | (s7_q & sin) | (s8_q & sin);

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    s7_d    = s7_q;
    s8_d    = s8_q;
    rx_d    = rx_q;
    new_d   = 1'b0;
    fe_d    = 1'b0;

    if (state_q > S_BREAK) begin
      // Unused encodings recover immediately, tick or not.
      state_d = S_IDLE;
    end else if (tick) begin
      os_d = os_q + 4'd1;
      if (os_q == 4'd7) s7_d = sin;
      if (os_q == 4'd8) s8_d = sin;

      case (state_q)
        S_IDLE: begin
          if (!sin) begin
            os_d    = 4'd0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (os_q == 4'd9 && vote) begin
            state_d = S_IDLE;           // glitch, start bit not held
          end else if (os_q == 4'd15) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end
        end
        S_DATA: begin
          if (os_q == 4'd9) begin
            shift_d = {vote, shift_q[7:1]};
          end else if (os_q == 4'd15) begin
            if (bit_q == 3'd7) state_d = S_STOP;
            else               bit_d   = bit_q + 3'd1;
          end
        end
        S_STOP: begin
          // Leave at mid-stop so a slightly fast transmitter or a
          // back-to-back start edge is still caught from IDLE.
          if (os_q == 4'd9) begin
            if (vote) begin
              rx_d    = shift_q;
              new_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // Wait for the line to come back high before hunting again.
          if (sin) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      s7_q    <= 1'b0;
      s8_q    <= 1'b0;
      rx_q    <= 8'h00;
      new_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      s7_q    <= s7_d;
      s8_q    <= s8_d;
      rx_q    <= rx_d;
      new_q   <= new_d;
      fe_q    <= fe_d;
    end
  end

  assign rx_data       = rx_q;
  assign new_rx_data   = new_q;
  assign framing_error = fe_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUD_DIV=4 (64 clocks per bit).
// The sender pushes every byte it expects to be received into a queue;
// a per-cycle checker pops it on each strobe and holds the last good byte
// as the required rx_data value.
module tb_uart_rx;
  localparam int BD  = 4;
  localparam int BIT = 16 * BD;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ser_in = 1'b1;
  logic [7:0] rx_data;
  logic       new_rx_data, framing_error, rx_busy;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clock(clock), .reset_n(reset_n), .ser_in(ser_in), .rx_data(rx_data),
    .new_rx_data(new_rx_data), .framing_error(framing_error), .rx_busy(rx_busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0, n_fail = 0;
  int n_strobe = 0, n_fe = 0, exp_fe = 0;
  bit fe_allow = 1'b0, busy_seen = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] model_last = 8'h00;
  logic prev_new = 1'b0, prev_fe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle checker, sampled away from the active edge.
  always @(negedge clock) begin
    if (!reset_n) begin
      chk("reset rx_data", rx_data, 8'h00);
      chk("reset new_rx_data", new_rx_data, 0);
      chk("reset framing_error", framing_error, 0);
      chk("reset rx_busy", rx_busy, 0);
      model_last = 8'h00;
      prev_new = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (new_rx_data) begin
        n_strobe++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected byte: got %0h, expected no strobe", rx_data);
        end else begin
          model_last = exp_q.pop_front();
        end
      end
      chk("rx_data", rx_data, model_last);
      chk("new/fe exclusive", new_rx_data & framing_error, 0);
      chk("new_rx_data width", new_rx_data & prev_new, 0);
      chk("framing_error width", framing_error & prev_fe, 0);
      if (framing_error) begin
        n_fe++;
        chk("framing_error allowed", fe_allow, 1);
      end
      if (rx_busy) busy_seen = 1'b1;
      prev_new = new_rx_data;
      prev_fe = framing_error;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One 8N1 frame; bit edges placed at round(k*per). Optional glitch of
  // glen clocks at offset goff inside frame bit gk (0=start, 1..8 data).
  task automatic send_frame(input logic [7:0] b, input real per, input logic stop_v,
                            input int gk, input int goff, input int glen, input bit expect_it);
    logic [9:0] fr;
    int dur;
    fr = {stop_v, b, 1'b0};
    if (expect_it) exp_q.push_back(b);
    for (int k = 0; k < 10; k++) begin
      dur = $rtoi((k + 1) * per + 0.5) - $rtoi(k * per + 0.5);
      ser_in = fr[k];
      if (k == gk) begin
        wait_clk(goff);
        ser_in = ~fr[k];
        wait_clk(glen);
        ser_in = fr[k];
        wait_clk(dur - goff - glen);
      end else begin
        wait_clk(dur);
      end
    end
    ser_in = 1'b1;
  endtask

  int s0, f0;
  logic [7:0] rb;

  initial begin
    wait_clk(5);
    chk("reset rx_data literal", rx_data, 8'h00);
    chk("reset rx_busy literal", rx_busy, 0);
    reset_n = 1'b1;
    wait_clk(2 * BIT);

    // Back-to-back frames, no idle gap.
    s0 = n_strobe;
    send_frame(8'hAA, BIT, 1'b1, -1, 0, 0, 1'b1);
    send_frame(8'h55, BIT, 1'b1, -1, 0, 0, 1'b1);
    wait_clk(32);
    chk("AA/55 strobes", n_strobe - s0, 2);
    chk("AA/55 last byte", rx_data, 8'h55);
    chk("AA/55 framing", n_fe, 0);

    // 12-clock low glitch from idle.
    s0 = n_strobe;
    busy_seen = 1'b0;
    ser_in = 1'b0;
    wait_clk(12);
    ser_in = 1'b1;
    wait_clk(40 * BD);
    chk("glitch busy pulsed", busy_seen, 1);
    chk("glitch back idle", rx_busy, 0);
    chk("glitch no strobe", n_strobe - s0, 0);
    chk("glitch no framing", n_fe, 0);

    // Stop bit low, line held low 40 bit times.
    f0 = n_fe;
    fe_allow = 1'b1;
    exp_fe++;
    send_frame(8'h3C, BIT, 1'b0, -1, 0, 0, 1'b0);
    ser_in = 1'b0;
    wait_clk(20 * BIT);
    chk("break busy mid", rx_busy, 1);
    wait_clk(20 * BIT);
    chk("break busy end", rx_busy, 1);
    chk("break one framing pulse", n_fe - f0, 1);
    chk("break rx_data kept", rx_data, 8'h55);
    ser_in = 1'b1;
    fe_allow = 1'b0;
    wait_clk(2 * BIT);
    chk("break released", rx_busy, 0);
    send_frame(8'h01, BIT, 1'b1, -1, 0, 0, 1'b1);
    wait_clk(32);
    chk("after break byte", rx_data, 8'h01);

    // Single-sample glitch on data bit 5 at the os_cnt=8 sample.
    send_frame(8'hF0, BIT, 1'b1, 6, 36, 4, 1'b1);
    wait_clk(32);
    chk("vote recovers bit", rx_data, 8'hF0);

    // Reset in the middle of bit 3 of a frame.
    s0 = n_strobe;
    ser_in = 1'b0;
    wait_clk(BIT);
    rb = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      ser_in = rb[k];
      wait_clk(BIT);
    end
    ser_in = rb[3];
    wait_clk(BIT / 2);
    chk("busy before reset", rx_busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset busy", rx_busy, 0);
    chk("async reset rx_data", rx_data, 8'h00);
    ser_in = 1'b1;
    wait_clk(20);
    reset_n = 1'b1;
    wait_clk(2 * BIT);
    chk("aborted frame no strobe", n_strobe - s0, 0);
    send_frame(8'h81, BIT, 1'b1, -1, 0, 0, 1'b1);
    wait_clk(32);
    chk("post reset byte", rx_data, 8'h81);
    chk("post reset one strobe", n_strobe - s0, 1);

    // Baud skew +3% then -3%, random bytes.
    s0 = n_strobe;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) begin
        send_frame(8'($urandom_range(0, 255)), (p == 0) ? BIT * 1.03 : BIT * 0.97,
                   1'b1, -1, 0, 0, 1'b1);
        wait_clk(16);
      end
    end
    wait_clk(2 * BIT);
    chk("skew strobes", n_strobe - s0, 32);
    chk("queue drained", exp_q.size(), 0);
    chk("framing total", n_fe, exp_fe);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
